// File: rtl/div_pkg.sv
// Shared types and constants for the clock-gated sequential divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DW_DEFAULT = 8;

  // Fill bit for a divide-by-zero quotient; replicated across the full quotient width.
  localparam logic DBZ_QUOT = 1'b1;

endpackage

// File: rtl/clock_gate_cell.sv
// Latch-based integrated clock gate: the enable is captured while clk is low,
// so gclk never glitches when en changes during the high phase.
module clock_gate_cell (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic r_en_lat;

  // Transparent-low enable latch.
  always_latch begin
    if (!clk) r_en_lat <= en;
  end

  assign gclk = clk & r_en_lat;

endmodule

// File: rtl/clock_gated_seq_div_8bit.sv
// Restoring divider, one quotient bit per gated clock. All state lives on the
// gated clock, so dropping en freezes the divider exactly where it is.
module clock_gated_seq_div_8bit
  import div_pkg::*;
#(
  parameter int DW    = DW_DEFAULT,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            start,
  input  logic [2*DW-1:0] dividend,
  input  logic [DW-1:0]   divisor,
  output logic            busy,
  output logic            done,
  output logic [2*DW-1:0] quotient,
  output logic [DW-1:0]   remainder,
  output logic            dbz
);

  logic w_gclk;

  clock_gate_cell u_icg (
    .clk  (clk),
    .en   (en),
    .gclk (w_gclk)
  );

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_count;
  logic [DW-1:0]     r_rem;
  logic [DW-1:0]     r_dvsr;
  logic [2*DW-1:0]   r_dvd;
  logic [2*DW-1:0]   r_quot;
  logic [DW-1:0]     r_remd;
  logic              r_done;
  logic              r_dbz;

  logic              w_accept;
  logic              w_last;
  logic [DW:0]       w_rem_sh;
  logic [DW+1:0]     w_trial;
  logic              w_qbit;
  logic [DW-1:0]     w_rem_nxt;
  logic [2*DW-1:0]   w_dvd_nxt;

  // One restoring step: shift the next dividend bit into the partial remainder,
  // then keep the subtraction only if it did not borrow. The extra MSB of the
  // trial is the borrow.
  assign w_rem_sh  = {r_rem, r_dvd[2*DW-1]};
  assign w_trial   = {1'b0, w_rem_sh} - {2'b00, r_dvsr};
  assign w_qbit    = ~w_trial[DW+1];
  assign w_rem_nxt = w_qbit ? w_trial[DW-1:0] : w_rem_sh[DW-1:0];
  assign w_dvd_nxt = {r_dvd[2*DW-2:0], w_qbit};
  assign w_last    = (r_count == CNT_W'(1));

  // Next-state logic; en needs no term here because the registers only see gated edges.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge w_gclk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // Operand capture, iteration and result registers.
  always_ff @(posedge w_gclk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_rem   <= '0;
      r_dvsr  <= '0;
      r_dvd   <= '0;
      r_quot  <= '0;
      r_remd  <= '0;
      r_done  <= 1'b0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dvsr <= divisor;
            r_dvd  <= dividend;
            r_rem  <= '0;
            if (divisor == '0) begin
              // Divide-by-zero short-circuits straight to a result.
              r_count <= '0;
              r_quot  <= {(2*DW){DBZ_QUOT}};
              r_remd  <= dividend[DW-1:0];
              r_dbz   <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_count <= CNT_W'(2*DW);
            end
          end
        end
        RUN: begin
          r_rem   <= w_rem_nxt;
          r_dvd   <= w_dvd_nxt;
          r_count <= r_count - CNT_W'(1);
          if (w_last) begin
            r_quot <= w_dvd_nxt;
            r_remd <= w_rem_nxt;
            r_dbz  <= 1'b0;
            r_done <= 1'b1;
          end
        end
        DONE:    r_done <= 1'b0;
        default: r_done <= 1'b0;
      endcase
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_remd;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_clock_gated_seq_div_8bit.sv
// Scoreboard bench for the clock-gated divider: stimulus pushes expected results,
// a negedge monitor pops and compares on each new done pulse.
module tb_clock_gated_seq_div_8bit;

  logic        clk = 1'b0;
  logic        rst, en, start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy, done, dbz;
  logic [15:0] quotient;
  logic [7:0]  remainder;

  clock_gated_seq_div_8bit dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: compare every fresh done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1 && prev_done !== 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("dbz", 32'(dbz), 32'(e.z));
      end
    end
    prev_done = done;
  end

  // Wait for idle, then present one request for a single edge. Returns at the
  // negedge of cycle 1 (the first cycle after the accept edge).
  task automatic issue(input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] q, input logic [7:0] r, input logic z);
    int   guard;
    exp_t e;
    guard = 0;
    en = 1'b1;
    while (busy && guard < 100) begin
      @(posedge clk); @(negedge clk);
      guard++;
    end
    if (busy) check("idle timeout", 32'd0, 32'd1);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.q = q; e.r = r; e.z = z;
    sb.push_back(e);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); @(negedge clk);
    end
  endtask

  // Wait for done starting from cycle c0; cyc is the cycle number where done is seen.
  task automatic wait_done(input int c0, input bit stall, output int cyc);
    cyc = c0;
    while (!done && cyc < 200) begin
      if (stall) en = ($urandom_range(0, 3) != 0);
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    en = 1'b1;
    if (!done) check("done timeout", 32'd0, 32'd1);
  endtask

  // Watchdog.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int          cyc;
    logic [15:0] a;
    logic [7:0]  b;

    rst = 1'b1; en = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #2 rst = 1'b0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset dbz", 32'(dbz), 32'd0);
    step(2);
    @(negedge clk) rst = 1'b1;

    // 1: basic divide and latency
    issue(16'd50, 8'd5, 16'd10, 8'd0, 1'b0);
    check("busy after accept", 32'(busy), 32'd1);
    wait_done(1, 1'b0, cyc);
    check("latency 50/5", 32'(cyc), 32'd17);

    // 2: directed vectors and boundaries
    issue(16'd65025, 8'd255, 16'd255, 8'd0, 1'b0);   wait_done(1, 1'b0, cyc);
    issue(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0);      wait_done(1, 1'b0, cyc);
    issue(16'd254, 8'd255, 16'd0, 8'd254, 1'b0);     wait_done(1, 1'b0, cyc);
    issue(16'd0, 8'd7, 16'd0, 8'd0, 1'b0);           wait_done(1, 1'b0, cyc);
    issue(16'd12345, 8'd1, 16'd12345, 8'd0, 1'b0);   wait_done(1, 1'b0, cyc);
    issue(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0);   wait_done(1, 1'b0, cyc);
    issue(16'd65535, 8'd254, 16'd258, 8'd3, 1'b0);   wait_done(1, 1'b0, cyc);
    issue(16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1);    wait_done(1, 1'b0, cyc);

    // 3: divide by zero, one-cycle result
    issue(16'd100, 8'd0, 16'hFFFF, 8'd100, 1'b1);
    check("dbz done cycle 1", 32'(done), 32'd1);
    check("dbz busy cycle 1", 32'(busy), 32'd1);
    step(1);
    check("dbz done drops", 32'(done), 32'd0);
    check("dbz busy drops", 32'(busy), 32'd0);

    // 4: five-cycle stall mid-run
    issue(16'd144, 8'd12, 16'd12, 8'd0, 1'b0);
    step(4);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      check("stall busy", 32'(busy), 32'd1);
      check("stall done", 32'(done), 32'd0);
      check("stall quotient", 32'(quotient), 32'hFFFF);
      check("stall remainder", 32'(remainder), 32'd100);
    end
    en = 1'b1;
    wait_done(10, 1'b0, cyc);
    check("latency with stall", 32'(cyc), 32'd22);

    // 5: start while busy is ignored
    issue(16'd4000, 8'd9, 16'd444, 8'd4, 1'b0);
    step(4);
    dividend = 16'd7; divisor = 8'd2; start = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(6, 1'b0, cyc);
    check("latency ignoring start", 32'(cyc), 32'd17);
    issue(16'd7, 8'd2, 16'd3, 8'd1, 1'b0);
    wait_done(1, 1'b0, cyc);

    // 6: asynchronous reset mid-run
    issue(16'd500, 8'd10, 16'd50, 8'd0, 1'b0);
    step(7);
    #2 rst = 1'b0;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quotient", 32'(quotient), 32'd0);
    check("abort remainder", 32'(remainder), 32'd0);
    check("abort dbz", 32'(dbz), 32'd0);
    void'(sb.pop_back());
    @(negedge clk) rst = 1'b1;
    issue(16'd500, 8'd10, 16'd50, 8'd0, 1'b0);
    wait_done(1, 1'b0, cyc);

    // Random pairs with random enable stalls
    for (int k = 0; k < 1000; k++) begin
      a = 16'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      if (b == 0) issue(a, b, 16'hFFFF, a[7:0], 1'b1);
      else        issue(a, b, a / 16'(b), 8'(a % 16'(b)), 1'b0);
      wait_done(1, 1'b1, cyc);
    end

    step(3);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
